// File: rtl/booth_pkg.sv
// Shared types and defaults for the Booth multiplier arbiter slice.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int DEF_NREQ        = 4;
  localparam int DEF_DIN0_W      = 16;
  localparam int DEF_DIN1_W      = 16;
  localparam int DEF_DOUT_W      = 32;
  localparam int DEF_TIMEOUT_CYC = 64;

  // Index width for a requester pointer; keeps a 1-bit pointer when NREQ=1.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin grant: first requester at or after rr_ptr, wrapping.
module rr_grant
  import booth_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int PTR_W = ptr_w(DEF_NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             grant_any
);

  logic [2*NREQ-1:0] dbl;

  // Doubling the request vector turns the wrap-around search into a plain
  // priority encode over bits at or above rr_ptr.
  always_comb begin
    // NOTE: every output gets a default before the search so no latch is inferred.
    dbl       = {req, req};
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < 2 * NREQ; k++) begin
      if (!grant_any && (k >= int'(rr_ptr)) && dbl[k]) begin
        grant_any = 1'b1;
        grant_idx = PTR_W'(k % NREQ);
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter sharing one sequential Booth multiplier among NREQ requesters.
module booth_mul_arbiter
  import booth_pkg::*;
#(
  parameter int NREQ        = DEF_NREQ,
  parameter int DIN0_W      = DEF_DIN0_W,
  parameter int DIN1_W      = DEF_DIN1_W,
  parameter int DOUT_W      = DEF_DOUT_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                     axis_clk,
  input  logic                     axis_rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*DIN0_W-1:0]   req_din0,
  input  logic [NREQ*DIN1_W-1:0]   req_din1,
  output logic [NREQ-1:0]          rsp_valid,
  input  logic [NREQ-1:0]          rsp_ready,
  output logic [DOUT_W-1:0]        rsp_dout,
  output logic                     rsp_err,
  output logic [DIN0_W-1:0]        mul_din0,
  output logic [DIN1_W-1:0]        mul_din1,
  output logic                     mul_start,
  input  logic                     mul_done,
  input  logic [DOUT_W-1:0]        mul_dout,
  output logic                     busy,
  output logic                     err_timeout
);

  localparam int PTR_W = ptr_w(NREQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_t           state, next_state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] g;
  logic [PTR_W-1:0] gnt_idx;
  logic [NREQ-1:0]  gnt;
  logic             gnt_any;
  logic [CNT_W-1:0] counter;
  logic             req_fire;
  logic             rsp_fire;
  logic             timeout_hit;

  rr_grant #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr_grant (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (gnt),
    .grant_idx (gnt_idx),
    .grant_any (gnt_any)
  );

  assign req_fire    = (state == IDLE) && gnt_any;
  assign rsp_fire    = (state == RESP) && rsp_ready[g];
  assign timeout_hit = (counter == CNT_W'(TIMEOUT_CYC));

  // Handshake strobes decode straight from state so an async reset drops them at once.
  always_comb begin
    req_ready = (state == IDLE) ? gnt : '0;
    rsp_valid = '0;
    if (state == RESP) rsp_valid[g] = 1'b1;
    mul_start = (state == START);
    busy      = (state != IDLE);
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_fire) next_state = START;
      START:   next_state = WAIT;
      WAIT:    if (mul_done || timeout_hit) next_state = RESP;
      RESP:    if (rsp_fire) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    // NOTE: registers are updated with <= so every flop samples pre-edge values.
    if (axis_rst) state <= IDLE;
    else          state <= next_state;
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      mul_din0    <= '0;
      mul_din1    <= '0;
      g           <= '0;
      rr_ptr      <= '0;
      counter     <= '0;
      rsp_dout    <= '0;
      rsp_err     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_fire) begin
            mul_din0 <= req_din0[gnt_idx*DIN0_W +: DIN0_W];
            mul_din1 <= req_din1[gnt_idx*DIN1_W +: DIN1_W];
            g        <= gnt_idx;
          end
        end
        START: counter <= '0;
        WAIT: begin
          counter <= counter + CNT_W'(1);
          // A real done in the same cycle as the watchdog expiry wins.
          if (mul_done) begin
            rsp_dout <= mul_dout;
            rsp_err  <= 1'b0;
          end else if (timeout_hit) begin
            rsp_dout    <= '0;
            rsp_err     <= 1'b1;
            err_timeout <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_fire) rr_ptr <= (g == PTR_W'(NREQ - 1)) ? '0 : g + PTR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Scoreboard bench for booth_mul_arbiter with a behavioural multiplier model.
module tb_booth_mul_arbiter;

  localparam int NREQ = 4;
  localparam int TO   = 64;

  logic             axis_clk;
  logic             axis_rst;
  logic [NREQ-1:0]  req_valid;
  logic [NREQ-1:0]  req_ready;
  logic [NREQ*16-1:0] req_din0;
  logic [NREQ*16-1:0] req_din1;
  logic [NREQ-1:0]  rsp_valid;
  logic [NREQ-1:0]  rsp_ready;
  logic [31:0]      rsp_dout;
  logic             rsp_err;
  logic [15:0]      mul_din0;
  logic [15:0]      mul_din1;
  logic             mul_start;
  logic             mul_done;
  logic [31:0]      mul_dout;
  logic             busy;
  logic             err_timeout;

  booth_mul_arbiter #(
    .NREQ(NREQ), .DIN0_W(16), .DIN1_W(16), .DOUT_W(32), .TIMEOUT_CYC(TO)
  ) dut (
    .axis_clk    (axis_clk),
    .axis_rst    (axis_rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_din0    (req_din0),
    .req_din1    (req_din1),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_dout    (rsp_dout),
    .rsp_err     (rsp_err),
    .mul_din0    (mul_din0),
    .mul_din1    (mul_din1),
    .mul_start   (mul_start),
    .mul_done    (mul_done),
    .mul_dout    (mul_dout),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  typedef struct {
    int          idx;
    logic [31:0] dout;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   grant_order[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_starts = 0;
  int n_rsps = 0;
  int accept_cyc = 0, start_cyc = 0, done_cyc = 0, rise_cyc = 0;
  logic [31:0] last_dout;
  logic        last_err;
  logic [NREQ-1:0] prev_rsp;

  int mul_lat  = 6;
  bit mul_hang = 1'b0;
  bit inj_done = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] smul(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] sa, sb;
    sa = 32'(signed'(a));
    sb = 32'(signed'(b));
    return sa * sb;
  endfunction

  initial begin
    axis_clk = 1'b0;
    forever #5 axis_clk = ~axis_clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Multiplier model: drives done/dout just after each rising edge.
  initial begin
    bit          pend;
    int          mcnt;
    logic [31:0] mprod;
    pend = 1'b0; mcnt = 0; mprod = '0;
    mul_done = 1'b0;
    mul_dout = '0;
    forever begin
      @(posedge axis_clk);
      #1;
      mul_done = 1'b0;
      if (axis_rst) begin
        pend = 1'b0;
      end else begin
        if (inj_done) begin
          mul_done = 1'b1;
          mul_dout = 32'hDEAD_BEEF;
          inj_done = 1'b0;
        end else if (pend) begin
          if (mcnt == 0) begin
            mul_done = 1'b1;
            mul_dout = mprod;
            pend     = 1'b0;
          end else begin
            mcnt--;
          end
        end
        if (mul_start && !mul_hang) begin
          pend  = 1'b1;
          mcnt  = mul_lat;
          mprod = smul(mul_din0, mul_din1);
        end
      end
    end
  end

  // Monitor: pushes expectations on request handshakes, pops on response handshakes.
  initial begin
    exp_t e;
    prev_rsp = '0;
    forever begin
      @(negedge axis_clk);
      cyc++;
      if (axis_rst) begin
        prev_rsp = '0;
      end else begin
        if (mul_start) begin
          n_starts++;
          start_cyc = cyc;
        end
        if (mul_done && busy) done_cyc = cyc;
        if (rsp_valid != '0 && prev_rsp == '0) rise_cyc = cyc;
        prev_rsp = rsp_valid;
        for (int i = 0; i < NREQ; i++) begin
          if (req_valid[i] && req_ready[i]) begin
            e.idx  = i;
            e.err  = mul_hang;
            e.dout = mul_hang ? 32'd0 : smul(req_din0[i*16 +: 16], req_din1[i*16 +: 16]);
            exp_q.push_back(e);
            grant_order.push_back(i);
            accept_cyc = cyc;
          end
        end
        if ((rsp_valid & rsp_ready) != '0) begin
          if (exp_q.size() == 0) begin
            check("rsp_unexpected", 64'(rsp_valid), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("rsp_owner", 64'(rsp_valid), 64'(1 << e.idx));
            check("rsp_dout", 64'(rsp_dout), 64'(e.dout));
            check("rsp_err", 64'(rsp_err), 64'(e.err));
            last_dout = rsp_dout;
            last_err  = rsp_err;
            n_rsps++;
          end
        end
      end
    end
  end

  task automatic send(input int i, input logic [15:0] a, input logic [15:0] b);
    bit ok;
    ok = 1'b0;
    @(posedge axis_clk);
    #1;
    req_din0[i*16 +: 16] = a;
    req_din1[i*16 +: 16] = b;
    req_valid[i] = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge axis_clk);
      if (req_ready[i]) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge axis_clk);
    #1;
    req_valid[i] = 1'b0;
    check("req_accept", 64'(ok), 64'd1);
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge axis_clk);
      if (n_rsps >= target && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 64'(ok), 64'd1);
  endtask

  initial begin
    int s0, r0, base, t;
    bit ok;
    logic [31:0] hold_dout;
    logic [15:0] ra [NREQ];
    logic [15:0] rb [NREQ];

    axis_rst  = 1'b1;
    req_valid = '0;
    req_din0  = '0;
    req_din1  = '0;
    rsp_ready = '1;

    // Reset state
    repeat (3) @(negedge axis_clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_dout", 64'(rsp_dout), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_mul_start", 64'(mul_start), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err_timeout", 64'(err_timeout), 64'd0);
    check("rst_mul_din", 64'({mul_din0, mul_din1}), 64'd0);
    @(posedge axis_clk);
    #1 axis_rst = 1'b0;

    // Single op
    s0 = n_starts; r0 = n_rsps;
    send(0, 16'h0003, 16'h0005);
    wait_done(r0 + 1, 80, "t1_complete");
    check("t1_start_pulses", 64'(n_starts - s0), 64'd1);
    check("t1_dout", 64'(last_dout), 64'd15);
    check("t1_err", 64'(last_err), 64'd0);
    check("t1_accept_to_start", 64'(start_cyc - accept_cyc), 64'd1);
    check("t1_done_to_rsp", 64'(rise_cyc - done_cyc), 64'd1);
    check("t1_within_40", 64'((rise_cyc - accept_cyc) <= 40), 64'd1);

    // Signed ops
    mul_lat = 30;
    r0 = n_rsps;
    send(0, 16'hFFFD, 16'h0007);
    wait_done(r0 + 1, 80, "t2a_complete");
    check("t2a_dout", 64'(last_dout), 64'hFFFF_FFEB);
    mul_lat = 2;
    send(1, 16'h8000, 16'h8000);
    wait_done(r0 + 2, 80, "t2b_complete");
    check("t2b_dout", 64'(last_dout), 64'h4000_0000);

    // Back-pressure on requester 1 while requester 2 waits
    mul_lat = 4;
    r0 = n_rsps;
    @(posedge axis_clk);
    #1 rsp_ready[1] = 1'b0;
    send(1, 16'h1234, 16'h0056);
    ok = 1'b0;
    for (int n = 0; n < 80; n++) begin
      @(negedge axis_clk);
      if (rsp_valid[1]) begin
        ok = 1'b1;
        break;
      end
    end
    check("t4_rsp_seen", 64'(ok), 64'd1);
    fork
      send(2, 16'h0011, 16'h0022);
    join_none
    hold_dout = rsp_dout;
    check("t4_hold_value", 64'(hold_dout), 64'h0006_1D78);
    s0 = n_starts;
    repeat (20) begin
      @(negedge axis_clk);
      check("t4_hold_valid", 64'(rsp_valid), 64'b0010);
      check("t4_hold_dout", 64'(rsp_dout), 64'(hold_dout));
      check("t4_hold_req_ready", 64'(req_ready), 64'd0);
    end
    check("t4_no_start", 64'(n_starts - s0), 64'd0);
    @(posedge axis_clk);
    #1 rsp_ready[1] = 1'b1;
    wait_done(r0 + 2, 120, "t4_complete");
    check("t4_next_dout", 64'(last_dout), 64'h0000_0242);

    // Watchdog timeout, then a normal op
    mul_hang = 1'b1;
    r0 = n_rsps;
    send(3, 16'h0009, 16'h0009);
    wait_done(r0 + 1, 200, "t5_complete");
    check("t5_err", 64'(last_err), 64'd1);
    check("t5_dout", 64'(last_dout), 64'd0);
    check("t5_err_timeout", 64'(err_timeout), 64'd1);
    t = rise_cyc - start_cyc;
    check("t5_timeout_window", 64'(t >= TO && t <= TO + 3), 64'd1);
    mul_hang = 1'b0;
    send(0, 16'h0007, 16'h0006);
    wait_done(r0 + 2, 80, "t5_next_complete");
    check("t5_next_dout", 64'(last_dout), 64'd42);
    check("t5_next_err", 64'(last_err), 64'd0);
    check("t5_sticky", 64'(err_timeout), 64'd1);

    // Reset in WAIT, then a stale done
    mul_hang = 1'b1;
    s0 = n_starts;
    send(1, 16'h0002, 16'h0002);
    repeat (10) @(posedge axis_clk);
    #1 axis_rst = 1'b1;
    exp_q.delete();
    #1;
    check("t6_started", 64'(n_starts - s0), 64'd1);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_mul_start", 64'(mul_start), 64'd0);
    check("t6_rsp_valid", 64'(rsp_valid), 64'd0);
    check("t6_outputs", 64'({rsp_dout, rsp_err, err_timeout, req_ready}), 64'd0);
    check("t6_mul_din", 64'({mul_din0, mul_din1}), 64'd0);
    @(posedge axis_clk);
    #1 axis_rst = 1'b0;
    mul_hang = 1'b0;
    inj_done = 1'b1;
    repeat (5) begin
      @(negedge axis_clk);
      check("t6_stale_done", 64'({busy, rsp_valid}), 64'd0);
    end

    // Round-robin with all requesters continuously valid
    ra[0] = 16'h0102; rb[0] = 16'h0003;
    ra[1] = 16'hFF00; rb[1] = 16'h0010;
    ra[2] = 16'h7FFF; rb[2] = 16'h7FFF;
    ra[3] = 16'h0001; rb[3] = 16'hFFFF;
    base = grant_order.size();
    r0   = n_rsps;
    @(posedge axis_clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      req_din0[i*16 +: 16] = ra[i];
      req_din1[i*16 +: 16] = rb[i];
    end
    req_valid = '1;
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(posedge axis_clk);
      #1;
      if (grant_order.size() >= base + 5) begin
        req_valid = '0;
        ok = 1'b1;
        break;
      end
    end
    req_valid = '0;
    check("t3_five_grants", 64'(ok), 64'd1);
    wait_done(r0 + 5, 120, "t3_complete");
    check("t3_grant_count", 64'(grant_order.size() - base), 64'd5);
    for (int k = 0; k < 5; k++) begin
      if (base + k < grant_order.size())
        check("t3_grant_order", 64'(grant_order[base + k]), 64'(k % NREQ));
      else
        check("t3_grant_missing", 64'(k), 64'(grant_order.size() - base));
    end

    repeat (3) @(negedge axis_clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
